// File: rtl/mesh_router_xy.sv
// 5-port XY mesh router node: per-input FIFOs, dimension-ordered
// routing, per-output round-robin arbitration, registered outputs.
module mesh_router_xy #(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 16,
  parameter int DEPTH   = 4,
  parameter int COLS    = 3,
  parameter int ROWS    = 3,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0,
  localparam int FLIT_W = 2*COORD_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5*FLIT_W-1:0] in_flit,
  input  logic [4:0]        in_valid,
  output logic [4:0]        in_ready,
  output logic [5*FLIT_W-1:0] out_flit,
  output logic [4:0]        out_valid,
  input  logic [4:0]        out_ready,
  output logic [7:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [COORD_W-1:0] CX = COORD_W'(COLS);
  localparam logic [COORD_W-1:0] CY = COORD_W'(ROWS);
  localparam logic [COORD_W-1:0] MX = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY = COORD_W'(MY_Y);
  localparam logic [2:0] R_DROP = 3'd5;

  logic [FLIT_W-1:0]  head [5];
  logic [COORD_W-1:0] dx [5];
  logic [COORD_W-1:0] dy [5];
  logic [2:0]         route [5];
  logic [4:0]         nonempty;
  logic [4:0]         push;
  logic [4:0]         pop;
  logic [4:0]         drop;
  logic [4:0]         loadable;
  logic [4:0]         grant_vld;
  logic [2:0]         grant_idx [5];
  logic [2:0]         rr_ptr [5];
  logic [FLIT_W-1:0]  out_q [5];
  logic [3:0]         sum;
  logic [2:0]         idx;
  logic [3:0]         ndrop;
  logic [8:0]         drop_sum;
  logic [7:0]         drop_q;

  for (genvar p = 0; p < 5; p++) begin : g_in
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    assign head[p]     = mem[rd_ptr];
    assign nonempty[p] = count != '0;
    assign in_ready[p] = !rst && count != FULL;
    assign push[p]     = in_valid[p] && in_ready[p];
    assign dx[p] = head[p][FLIT_W-1 -: COORD_W];
    assign dy[p] = head[p][DATA_W +: COORD_W];
    assign route[p] =
      (dx[p] >= CX || dy[p] >= CY) ? R_DROP :
      (dx[p] > MX) ? 3'd2 :
      (dx[p] < MX) ? 3'd1 :
      (dy[p] > MY) ? 3'd4 :
      (dy[p] < MY) ? 3'd3 : 3'd0;
    assign drop[p] = nonempty[p] && route[p] == R_DROP;
    assign out_flit[p*FLIT_W +: FLIT_W] = out_q[p];
    assign loadable[p] = !out_valid[p] || out_ready[p];

    always_ff @(posedge clk) begin
      if (push[p]) mem[wr_ptr] <= in_flit[p*FLIT_W +: FLIT_W];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[p]) wr_ptr <= wr_ptr + AW'(1);
        if (pop[p])  rd_ptr <= rd_ptr + AW'(1);
        unique case ({push[p], pop[p]})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Scan inputs cyclically from rr_ptr; first matching head wins.
  always_comb begin
    grant_vld = '0;
    sum = '0;
    idx = '0;
    for (int o = 0; o < 5; o++) begin
      grant_idx[o] = '0;
      for (int k = 0; k < 5; k++) begin
        sum = {1'b0, rr_ptr[o]} + 4'(k);
        idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
        if (!grant_vld[o] && loadable[o] &&
            nonempty[idx] && route[idx] == 3'(o)) begin
          grant_vld[o] = 1'b1;
          grant_idx[o] = idx;
        end
      end
    end
  end

  always_comb begin
    pop = drop;
    for (int o = 0; o < 5; o++)
      if (grant_vld[o]) pop[grant_idx[o]] = 1'b1;
  end

  always_comb begin
    ndrop = '0;
    for (int p = 0; p < 5; p++)
      ndrop = ndrop + {3'b000, drop[p]};
    drop_sum = {1'b0, drop_q} + {5'b0, ndrop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < 5; o++) begin
        out_q[o]     <= '0;
        out_valid[o] <= 1'b0;
        rr_ptr[o]    <= '0;
      end
      drop_q <= '0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (grant_vld[o]) begin
          out_q[o]     <= head[grant_idx[o]];
          out_valid[o] <= 1'b1;
          rr_ptr[o]    <= (grant_idx[o] == 3'd4) ?
                          3'd0 : grant_idx[o] + 3'd1;
        end else if (out_ready[o]) begin
          out_valid[o] <= 1'b0;
        end
      end
      drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_mesh_router_xy.sv
// Self-checking bench for mesh_router_xy at node (1,1) of a 3x3 mesh,
// compared each cycle against a queue-based reference model.
module tb_mesh_router_xy;
  localparam int FW    = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic [5*FW-1:0] in_flit;
  logic [4:0] in_valid;
  logic [4:0] in_ready;
  logic [5*FW-1:0] out_flit;
  logic [4:0] out_valid;
  logic [4:0] out_ready;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  mesh_router_xy #(
    .DATA_W(32), .COORD_W(16), .DEPTH(DEPTH),
    .COLS(3), .ROWS(3), .MY_X(1), .MY_Y(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_valid(in_valid),
    .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid),
    .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  logic [FW-1:0] mq [5][$];
  bit            mv [5];
  logic [FW-1:0] mo [5];
  int            rr [5];
  int            mdc;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag,
                       logic [63:0] obs,
                       logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mkflit(
      int x, int y, logic [31:0] d);
    logic [15:0] xs;
    logic [15:0] ys;
    xs = x[15:0];
    ys = y[15:0];
    return {xs, ys, d};
  endfunction

  function automatic int route_of(logic [FW-1:0] f);
    int x;
    int y;
    x = int'(f[63:48]);
    y = int'(f[47:32]);
    if (x >= 3 || y >= 3) return 5;
    if (x > 1) return 2;
    if (x < 1) return 1;
    if (y > 1) return 4;
    if (y < 1) return 3;
    return 0;
  endfunction

  function automatic logic [FW-1:0] lane(int p);
    return out_flit[p*FW +: FW];
  endfunction

  task automatic step();
    bit acc [5];
    bit pop [5];
    logic [FW-1:0] inl [5];
    logic [4:0] erdy;
    logic [4:0] evld;
    bit found;
    int g;
    int nd;
    for (int p = 0; p < 5; p++) begin
      acc[p] = in_valid[p] && !rst &&
               mq[p].size() != DEPTH;
      inl[p] = in_flit[p*FW +: FW];
      pop[p] = 0;
    end
    @(posedge clk);
    if (rst) begin
      for (int p = 0; p < 5; p++) begin
        mq[p].delete();
        mv[p] = 0;
        mo[p] = '0;
        rr[p] = 0;
      end
      mdc = 0;
    end else begin
      nd = 0;
      for (int o = 0; o < 5; o++) begin
        if (!mv[o] || out_ready[o]) begin
          found = 0;
          for (int k = 0; k < 5; k++) begin
            g = (rr[o] + k) % 5;
            if (!found && mq[g].size() > 0 &&
                route_of(mq[g][0]) == o) begin
              found = 1;
              mo[o] = mq[g][0];
              mv[o] = 1;
              pop[g] = 1;
              rr[o] = (g + 1) % 5;
            end
          end
          if (!found && out_ready[o]) mv[o] = 0;
        end
      end
      for (int p = 0; p < 5; p++)
        if (mq[p].size() > 0 &&
            route_of(mq[p][0]) == 5) begin
          nd++;
          pop[p] = 1;
        end
      mdc = (mdc + nd > 255) ? 255 : mdc + nd;
      for (int p = 0; p < 5; p++) begin
        if (pop[p]) void'(mq[p].pop_front());
        if (acc[p]) mq[p].push_back(inl[p]);
      end
    end
    #1;
    for (int p = 0; p < 5; p++) begin
      erdy[p] = !rst && mq[p].size() != DEPTH;
      evld[p] = mv[p];
    end
    check("in_ready", 64'(in_ready), 64'(erdy));
    check("out_valid", 64'(out_valid), 64'(evld));
    for (int o = 0; o < 5; o++)
      if (mv[o]) check("out_flit", lane(o), mo[o]);
    check("drop_cnt", 64'(drop_cnt), 64'(mdc));
  endtask

  task automatic send_local(int x, int y,
                            logic [31:0] d, int port);
    logic [FW-1:0] f;
    logic [4:0] ev;
    f = mkflit(x, y, d);
    in_flit[0 +: FW] = f;
    in_valid = 5'b00001;
    step();
    in_valid = '0;
    step();
    ev = 5'(1 << port);
    check("route_valid", 64'(out_valid), 64'(ev));
    check("route_flit", lane(port), f);
    step();
  endtask

  int idx;
  int got;
  logic rdy;

  initial begin
    rst = 1'b1;
    in_flit = '0;
    in_valid = 5'h1F;
    out_ready = 5'h1F;
    for (int p = 0; p < 5; p++) begin
      mv[p] = 0; mo[p] = '0; rr[p] = 0;
    end
    mdc = 0;

    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_drop", 64'(drop_cnt), 64'h0);
    rst = 1'b0;
    in_valid = '0;
    step();
    check("rel_in_ready", 64'(in_ready), 64'h1F);
    step();
    check("rel_out_valid", 64'(out_valid), 64'h0);

    send_local(2, 1, 32'hA5A5A5A5, 2);
    send_local(0, 2, 32'h11111111, 1);
    send_local(1, 0, 32'h22222222, 3);
    send_local(1, 2, 32'h33333333, 4);
    send_local(1, 1, 32'h44444444, 0);

    for (int p = 1; p < 5; p++)
      in_flit[p*FW +: FW] = mkflit(1, 1, 32'hC0 + p);
    in_valid = 5'b11110;
    step();
    in_valid = '0;
    for (int k = 1; k < 5; k++) begin
      step();
      check("arb_valid", 64'(out_valid[0]), 64'h1);
      check("arb_order", lane(0),
            mkflit(1, 1, 32'hC0 + k));
    end
    step();
    check("arb_idle", 64'(out_valid), 64'h0);

    in_flit[0 +: FW]  = mkflit(1, 1, 32'hD0);
    in_flit[FW +: FW] = mkflit(1, 1, 32'hD1);
    in_valid = 5'b00011;
    step();
    in_valid = '0;
    step();
    check("rr_wrap0", lane(0), mkflit(1, 1, 32'hD0));
    step();
    check("rr_wrap1", lane(0), mkflit(1, 1, 32'hD1));
    step();

    out_ready = 5'b11011;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_flit[0 +: FW] = mkflit(2, 1, 32'hB000 + idx);
      in_valid = 5'b00001;
      rdy = in_ready[0];
      step();
      if (rdy) idx++;
    end
    in_valid = '0;
    check("bp_accepted", 64'(idx), 64'd5);
    check("bp_full", 64'(in_ready[0]), 64'h0);
    check("bp_hold_v", 64'(out_valid[2]), 64'h1);
    check("bp_hold", lane(2), mkflit(2, 1, 32'hB000));
    out_ready = 5'h1F;
    got = 1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid[2]) begin
        check("bp_order", lane(2),
              mkflit(2, 1, 32'hB000 + got));
        got++;
      end
    end
    check("bp_count", 64'(got), 64'd5);
    check("bp_ready", 64'(in_ready[0]), 64'h1);

    in_flit[0 +: FW] = mkflit(3, 0, 32'hE0);
    in_valid = 5'b00001;
    step();
    in_flit[0 +: FW] = mkflit(0, 5, 32'hE1);
    step();
    in_valid = '0;
    step();
    step();
    check("drop_two", 64'(drop_cnt), 64'd2);
    check("drop_none", 64'(out_valid), 64'h0);
    in_valid = 5'b00001;
    for (int i = 0; i < 300; i++) begin
      in_flit[0 +: FW] = mkflit(5, 5, i);
      step();
    end
    in_valid = '0;
    step();
    step();
    check("drop_sat", 64'(drop_cnt), 64'd255);

    out_ready = '0;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 5; p++)
        in_flit[p*FW +: FW] = mkflit(
          $urandom_range(0, 2), $urandom_range(0, 2),
          $urandom);
      in_valid = 5'h1F;
      step();
    end
    check("mid_busy", 64'(|out_valid), 64'h1);
    rst = 1'b1;
    step();
    check("mid_rst_v", 64'(out_valid), 64'h0);
    check("mid_rst_r", 64'(in_ready), 64'h0);
    check("mid_rst_d", 64'(drop_cnt), 64'h0);
    rst = 1'b0;
    in_valid = '0;
    out_ready = 5'h1F;
    for (int c = 0; c < 6; c++) begin
      step();
      check("mid_stale", 64'(out_valid), 64'h0);
    end
    check("mid_ready", 64'(in_ready), 64'h1F);

    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 5; p++) begin
        in_flit[p*FW +: FW] = mkflit(
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom);
        out_ready[p] = ($urandom_range(0, 3) != 0);
      end
      in_valid = 5'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
